branch_target_buffer: RTL
=========================

Name: branch_target_buffer

Overview:
Direct-mapped branch target buffer with per-entry 2-bit saturating predictors. It sits in the fetch stage, upstream of decode/control. It predicts the next fetch PC from the current PC and is trained by resolved branch/jump outcomes from the memory stage. Its mispredict information is what later drives the control unit's corrected-branch and wrong-type PC recovery.

Parameters:
ENTRIES, 16, number of table entries; power of two, minimum 2
IDX_W, $clog2(ENTRIES), index width; derived, not overridden

Ports:
CLK  in  1  system clock; all state updates on rising edge
RST  in  1  synchronous, active-high reset
pc  in  32 (word_t)  current fetch PC
pred_hit  out  1  valid entry whose tag matches pc
pred_take  out  1  prediction is taken: pred_hit & ctr[1]
pred_npc  out  32 (word_t)  predicted next PC: stored target if pred_take, else pc+4
upd_en  in  1  resolved control-flow instruction present in memory stage this cycle
upd_pc  in  32 (word_t)  PC of the resolved instruction
upd_taken  in  1  actual outcome was taken (always 1 for J/JAL/JR)
upd_target  in  32 (word_t)  actual target address
upd_jump  in  1  resolved instruction is an unconditional jump
upd_wrongtype  in  1  entry hit for upd_pc, but the instruction is not a branch/jump; invalidate the entry

Behaviour:
- Entry fields: valid, tag[31:IDX_W+2], target[31:2], ctr[1:0].
- Index = pc[IDX_W+1:2]. Tag = pc[31:IDX_W+2]. pc[1:0] ignored. Stored targets have [1:0] = 2'b00.
- Lookup path is purely combinational from registered table state, with zero latency.
  - pred_npc = pred_take ? {target,2'b00} : pc + 32'd4.
  - pc + 4 wraps modulo 2^32: 0xFFFFFFFC -> 0x00000000.
- Reset (RST high at posedge): every valid bit = 0; every ctr = 2'b01; tags and targets = 0.
  - Outputs after reset: pred_hit = 0, pred_take = 0, pred_npc = pc+4.
  - RST has priority over a concurrent upd_en; that update is discarded.
- Update at posedge when upd_en = 1 (ui = index of upd_pc, ut = its tag). Exactly one case applies, priority top-down:
  1. upd_wrongtype: valid[ui] = 0; ctr[ui] = 2'b01; other fields unchanged.
  2. Hit (valid & tag match) and upd_jump: ctr = 2'b11; target = upd_target[31:2].
  3. Hit and upd_taken: ctr = sat_inc(ctr) (max 2'b11); target = upd_target[31:2].
  4. Hit and not taken: ctr = sat_dec(ctr) (min 2'b00); target unchanged; entry stays valid.
  5. Miss and (upd_taken or upd_jump): allocate/replace, setting valid = 1, tag = ut, target = upd_target[31:2], ctr = upd_jump ? 2'b11 : 2'b10.
  6. Miss and not taken: no change (no allocation).
- Same-cycle lookup and update to the same index: lookup reflects pre-update contents; the new value is visible the cycle after the edge.
- upd_en = 0: table holds. upd_wrongtype/upd_taken/upd_jump are ignored unless upd_en = 1.
- Aliasing: a different tag at the same index is replaced only on case 5. No associativity and no LRU.
- No stall input. The upstream stage presents a stable pc while stalled, and outputs track pc combinationally.

Decomposition:
- Add btb_entry_t (packed struct: valid, tag, target, ctr) to cpu_types_pkg.
- Add constants to cpu_types_pkg: BTB_CTR_WEAK_T = 2'b10, BTB_CTR_STRONG_T = 2'b11, BTB_CTR_RESET = 2'b01.
- Sub-module sat_counter2: pure combinational next-state (inc/dec/force) for the 2-bit counter, reused by future predictors.
- Table storage is flip-flops, not an SRAM macro.

Test Plan:
- Reset: assert RST 1 cycle, drive pc = 0x00000040 -> pred_hit = 0, pred_take = 0, pred_npc = 0x00000044.
- Taken-branch allocate: upd_en, upd_pc = 0x40, upd_taken = 1, upd_target = 0x100; next cycle pc = 0x40 -> pred_hit = 1, pred_take = 1, pred_npc = 0x100. Same-cycle lookup during the update -> pred_npc = 0x44.
- Counter hysteresis: after allocate (ctr = 10), one not-taken -> ctr 01, pred_take = 0, pred_npc = 0x44. Three taken -> ctr saturates at 11. Two not-taken -> ctr 01.
- Jump and aliasing (ENTRIES = 16): allocate 0x40 -> 0x100. Then jump at upd_pc = 0x80 (same index, different tag) with target 0x200 -> pc = 0x40 misses; pc = 0x80 gives pred_npc = 0x200 with ctr = 11.
- Wrong type: hit entry at 0x40, then upd_en + upd_wrongtype + upd_taken -> entry invalid, pc = 0x40 gives pred_hit = 0, pred_npc = 0x44. Also check: miss + not taken allocates nothing; wrap pc = 0xFFFFFFFC gives pred_npc = 0x00000000.
- Reset mid-operation: RST and upd_en (allocating 0x40) in the same cycle -> table empty afterwards, pc = 0x40 gives pred_hit = 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types and constants: word type, BTB entry layout and predictor counter encodings.
package cpu_types_pkg;

  localparam int unsigned WORD_W        = 32;
  // Widest tag needed (ENTRIES = 2 leaves 29 tag bits); narrower configs zero-extend.
  localparam int unsigned BTB_TAG_MAX_W = 29;
  localparam int unsigned BTB_TGT_W     = 30;

  typedef logic [WORD_W-1:0] word_t;

  localparam logic [1:0] BTB_CTR_WEAK_T   = 2'b10;
  localparam logic [1:0] BTB_CTR_STRONG_T = 2'b11;
  localparam logic [1:0] BTB_CTR_RESET    = 2'b01;

  typedef struct packed {
    logic                     valid;
    logic [BTB_TAG_MAX_W-1:0] tag;
    logic [BTB_TGT_W-1:0]     target;
    logic [1:0]               ctr;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Combinational next-state for a 2-bit saturating counter with force override.
module sat_counter2 (
  input  logic [1:0] i_ctr,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic       i_force,
  input  logic [1:0] i_force_val,
  output logic [1:0] o_ctr_c
);

  always_comb begin
    o_ctr_c = i_ctr;
    if (i_force) begin
      o_ctr_c = i_force_val;
    end else if (i_inc) begin
      if (i_ctr != 2'b11) o_ctr_c = 2'(i_ctr + 2'd1);
    end else if (i_dec) begin
      if (i_ctr != 2'b00) o_ctr_c = 2'(i_ctr - 2'd1);
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit predictors: zero-latency lookup on pc, trained by resolved branches.
module branch_target_buffer
  import cpu_types_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
  input  logic  CLK,
  input  logic  RST,
  input  word_t pc,
  output logic  pred_hit,
  output logic  pred_take,
  output word_t pred_npc,
  input  logic  upd_en,
  input  word_t upd_pc,
  input  logic  upd_taken,
  input  word_t upd_target,
  input  logic  upd_jump,
  input  logic  upd_wrongtype
);

  btb_entry_t r_table [ENTRIES];

  logic [IDX_W-1:0]         w_idx;
  logic [BTB_TAG_MAX_W-1:0] w_tag;
  btb_entry_t               w_ent;

  logic [IDX_W-1:0]         w_uidx;
  logic [BTB_TAG_MAX_W-1:0] w_utag;
  btb_entry_t               w_uent;
  logic                     w_uhit;
  logic [1:0]               w_ctr_next;
  btb_entry_t               w_new_ent;
  logic                     w_wr;
  logic                     w_unused;

  // Lookup: reads registered state only, so same-cycle updates are not visible.
  assign w_idx     = pc[IDX_W+1:2];
  assign w_tag     = BTB_TAG_MAX_W'(pc >> (IDX_W + 2));
  assign w_ent     = r_table[w_idx];
  assign pred_hit  = w_ent.valid && (w_ent.tag == w_tag);
  assign pred_take = pred_hit && w_ent.ctr[1];
  assign pred_npc  = pred_take ? {w_ent.target, 2'b00} : word_t'(pc + 32'd4);

  assign w_uidx   = upd_pc[IDX_W+1:2];
  assign w_utag   = BTB_TAG_MAX_W'(upd_pc >> (IDX_W + 2));
  assign w_uent   = r_table[w_uidx];
  assign w_uhit   = w_uent.valid && (w_uent.tag == w_utag);
  assign w_unused = ^upd_target[1:0];

  sat_counter2 u_ctr (
    .i_ctr       (w_uent.ctr),
    .i_inc       (upd_taken),
    .i_dec       (!upd_taken),
    .i_force     (upd_jump),
    .i_force_val (BTB_CTR_STRONG_T),
    .o_ctr_c     (w_ctr_next)
  );

  // Training decision; priority order matters (wrong-type beats hit beats allocate).
  always_comb begin
    w_new_ent = w_uent;
    w_wr      = 1'b0;
    if (upd_wrongtype) begin
      w_new_ent.valid = 1'b0;
      w_new_ent.ctr   = BTB_CTR_RESET;
      w_wr            = 1'b1;
    end else if (w_uhit) begin
      w_new_ent.ctr = w_ctr_next;
      if (upd_jump || upd_taken) w_new_ent.target = upd_target[31:2];
      w_wr = 1'b1;
    end else if (upd_taken || upd_jump) begin
      w_new_ent.valid  = 1'b1;
      w_new_ent.tag    = w_utag;
      w_new_ent.target = upd_target[31:2];
      w_new_ent.ctr    = upd_jump ? BTB_CTR_STRONG_T : BTB_CTR_WEAK_T;
      w_wr             = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_table[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: BTB_CTR_RESET};
      end
    end else if (upd_en && w_wr) begin
      r_table[w_uidx] <= w_new_ent;
    end
  end

endmodule
